decodificador_comando: RTL and testbench
========================================

# decodificador_comando

Command-layer controller directly downstream of the UART receiver. It pairs the receiver's two byte outputs (command, then address) into a request frame and validates it. It then drives one transaction on the sensor interface and returns a two-byte response (code, data) through the UART transmitter handshake. Requests that arrive while the block is busy are held in a one-deep pending slot.

## Interface
- CLOCKS_TIMEOUT, 50_000_000: cycles to wait for `sensorPronto` before declaring a sensor fault (1 s at 50 MHz).
- NUM_SENSORES, 32: valid addresses are 0..NUM_SENSORES-1 (max 32).

- clock  in  1  system clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- bytesRecebidos  in  1  one-cycle pulse per byte from the receiver.
- primeiroByte  in  8  command byte from the receiver; stable when the second pulse of a pair arrives.
- segundoByte  in  8  address byte from the receiver; stable when the second pulse of a pair arrives.
- sensorRequisicao  out  1  one-cycle request strobe.
- sensorEndereco  out  5  sensor address; valid with the strobe and held until the transaction ends.
- sensorTipo  out  2  0 = status, 1 = temperature, 2 = humidity.
- sensorPronto  in  1  one-cycle completion pulse.
- sensorDado  in  8  measurement; sampled when `sensorPronto` is high.
- sensorErro  in  1  fault flag; sampled when `sensorPronto` is high.
- txInicia  out  1  one-cycle start strobe to the transmitter.
- txByte  out  8  byte to send; held until the next `txInicia`.
- txOcupado  in  1  transmitter busy.
- txConcluido  in  1  one-cycle pulse marking the end of a byte.
- ocupado  out  1  high in every state except ESPERA.

## Operation
- **Pair tracking.** A parity bit toggles on every `bytesRecebidos` pulse. The second pulse of a pair latches {primeiroByte, segundoByte} into the pending slot on the next edge.
  - Parity toggles regardless of FSM state.
  - If the slot is already full, the new pair is dropped.
- **Command map.** Each command lists its sensor type (if any), then the response code and data byte.
  - 0x00 status: type 0. Response 0x07 with data 0x00, or 0x1F with 0x00 on fault.
  - 0x01 temperature: type 1. Response 0x09 with `sensorDado`.
  - 0x02 humidity: type 2. Response 0x08 with `sensorDado`.
  - Any other command: response 0xCF with data 0x00.
- **Address check.** Applied after the command check. An address >= NUM_SENSORES gives response 0xEF with data 0x00.
- **Sensor faults.** `sensorErro`=1 or a timeout on any measurement gives response 0x1F with data 0x00.
- **FSM states:**
  - ESPERA: if the slot is full, pop it into the working registers and go to VALIDA.
  - VALIDA: invalid request goes to ENVIA_CODIGO. Valid request goes to REQUISITA.
  - REQUISITA: pulse `sensorRequisicao`, clear the timeout counter, go to AGUARDA_SENSOR.
  - AGUARDA_SENSOR: on `sensorPronto`, capture the result and go to ENVIA_CODIGO. If the counter reaches CLOCKS_TIMEOUT-1, load the fault response and go to ENVIA_CODIGO.
  - ENVIA_CODIGO: wait for `txOcupado`=0, pulse `txInicia` with the code byte, go to AGUARDA_TX1.
  - AGUARDA_TX1: on `txConcluido`, go to ENVIA_DADO.
  - ENVIA_DADO: same as ENVIA_CODIGO but sends the data byte, then goes to AGUARDA_TX2.
  - AGUARDA_TX2: on `txConcluido`, go to ESPERA.
- **Arithmetic.** The timeout counter is 26 bits and saturates. The address compare uses all 8 bits, so 0xFF is invalid.

## Timing
- **Reset values.** All outputs are 0. The FSM is in ESPERA, the slot is empty, parity = first byte, and the counter is 0.
  - Reset takes effect immediately, including mid-transaction. Any partially transmitted response is abandoned.
- **Latency.** The second pulse at edge N gives slot full at N+1, VALIDA at N+2, and `sensorRequisicao` at N+3.
- **Invalid request latency.** An invalid request with an idle transmitter gives `txInicia` at N+3.
- **Simultaneous events:**
  - `sensorPronto` in the timeout cycle: `sensorPronto` wins.
  - Pair completion in the same cycle the slot is popped: the new pair is stored, because the pop happens first.
  - `txConcluido` outside AGUARDA_TX1/TX2 is ignored.
- **Output hold.** `sensorEndereco` and `sensorTipo` hold from REQUISITA until they are next loaded.

## Configuration
- **CONTINUOUS_MODE_EN defined:**
  - Command 0x03 sets the continuous-temperature flag; 0x04 sets the continuous-humidity flag. Both still pass the address check.
  - Each performs a normal measurement and response, then re-triggers in ESPERA whenever the slot is empty. Temperature takes priority if both flags are set.
  - Command 0x05 clears the temperature flag and responds 0x0A with data 0x00. Command 0x06 clears the humidity flag and responds 0x0B with data 0x00.
  - A pending pair always takes priority over a re-trigger.
  - A sensor fault clears the corresponding flag.
- **CONTINUOUS_MODE_EN undefined:** commands 0x03..0x06 respond 0xCF and no flag logic exists.

## Test plan
- Pair 0x01/0x05, sensor returns 25 after 100 cycles -> request with addr 5, type 1; tx sends 0x09 then 0x19.
- Pair 0x02/0x20 -> no sensor request; tx sends 0xEF, 0x00. Pair 0x7A/0x00 -> 0xCF, 0x00.
- Pair 0x00/0x03 with `sensorPronto` never asserted (CLOCKS_TIMEOUT=1000) -> `txInicia` with 0x1F right after 1000 waiting cycles, then 0x00.
- Three pairs back-to-back while the first is waiting on the sensor -> second is served after the first, third is dropped; exactly four tx bytes are sent.
- `resetN` low during AGUARDA_TX1 -> all outputs are 0 at once; the next pair is processed normally starting from parity 0.
- CONTINUOUS_MODE_EN: 0x03/0x01 -> repeated 0x09 responses; 0x05/0x01 -> 0x0A, 0x00 and the repeats stop.

Source files
------------

// File: rtl/decodificador_comando.sv
// decodificador_comando: pairs UART bytes into requests, runs a sensor read, replies with code+data.
// Ports: receiver (bytesRecebidos/primeiroByte/segundoByte), sensor req/resp, tx handshake, ocupado.
// Optional macro CONTINUOUS_MODE_EN adds commands 0x03..0x06 (continuous temp/humidity re-trigger).
module decodificador_comando #(
    parameter int CLOCKS_TIMEOUT = 50_000_000,
    parameter int NUM_SENSORES   = 32
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       bytesRecebidos,
    input  logic [7:0] primeiroByte,
    input  logic [7:0] segundoByte,
    output logic       sensorRequisicao,
    output logic [4:0] sensorEndereco,
    output logic [1:0] sensorTipo,
    input  logic       sensorPronto,
    input  logic [7:0] sensorDado,
    input  logic       sensorErro,
    output logic       txInicia,
    output logic [7:0] txByte,
    input  logic       txOcupado,
    input  logic       txConcluido,
    output logic       ocupado
);

    typedef enum logic [2:0] {
        ESPERA,
        VALIDA,
        REQUISITA,
        AGUARDA_SENSOR,
        ENVIA_CODIGO,
        AGUARDA_TX1,
        ENVIA_DADO,
        AGUARDA_TX2
    } estado_t;

    localparam logic [25:0] CNT_LIMITE = 26'(CLOCKS_TIMEOUT - 1);
    localparam logic [8:0]  END_LIMITE = 9'(NUM_SENSORES);

    estado_t     estado_q, estado_d;
    logic        paridade_q, paridade_d;
    logic        slot_cheio_q, slot_cheio_d;
    logic [7:0]  slot_cmd_q, slot_cmd_d;
    logic [7:0]  slot_addr_q, slot_addr_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  addr_q, addr_d;
    logic [4:0]  endereco_q, endereco_d;
    logic [1:0]  tipo_q, tipo_d;
    logic [7:0]  cod_q, cod_d;
    logic [7:0]  dado_q, dado_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [25:0] cnt_q, cnt_d;
`ifdef CONTINUOUS_MODE_EN
    logic        cont_temp_q, cont_temp_d;
    logic        cont_hum_q, cont_hum_d;
    logic [7:0]  cont_temp_addr_q, cont_temp_addr_d;
    logic [7:0]  cont_hum_addr_q, cont_hum_addr_d;
`endif

    logic       pop;
    logic       par_completo;
    logic       cmd_ok;
    logic       addr_ok;
    logic       usa_sensor;
    logic [1:0] tipo_cmd;
    logic [7:0] cod_imed;

    // Command decode of the working request
    always_comb begin
        cmd_ok     = 1'b1;
        usa_sensor = 1'b1;
        tipo_cmd   = 2'd0;
        cod_imed   = 8'hCF;
        case (cmd_q)
            8'h00: tipo_cmd = 2'd0;
            8'h01: tipo_cmd = 2'd1;
            8'h02: tipo_cmd = 2'd2;
`ifdef CONTINUOUS_MODE_EN
            8'h03: tipo_cmd = 2'd1;
            8'h04: tipo_cmd = 2'd2;
            8'h05: begin
                usa_sensor = 1'b0;
                cod_imed   = 8'h0A;
            end
            8'h06: begin
                usa_sensor = 1'b0;
                cod_imed   = 8'h0B;
            end
`endif
            default: begin
                cmd_ok     = 1'b0;
                usa_sensor = 1'b0;
            end
        endcase
        addr_ok = ({1'b0, addr_q} < END_LIMITE);
    end

    always_comb begin
        estado_d     = estado_q;
        paridade_d   = paridade_q ^ bytesRecebidos;
        slot_cheio_d = slot_cheio_q;
        slot_cmd_d   = slot_cmd_q;
        slot_addr_d  = slot_addr_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        endereco_d   = endereco_q;
        tipo_d       = tipo_q;
        cod_d        = cod_q;
        dado_d       = dado_q;
        tx_byte_d    = tx_byte_q;
        cnt_d        = cnt_q;
`ifdef CONTINUOUS_MODE_EN
        cont_temp_d      = cont_temp_q;
        cont_hum_d       = cont_hum_q;
        cont_temp_addr_d = cont_temp_addr_q;
        cont_hum_addr_d  = cont_hum_addr_q;
`endif

        // Pop is evaluated before the fill so a pair finishing in the
        // pop cycle still finds room.
        pop          = (estado_q == ESPERA) && slot_cheio_q;
        par_completo = bytesRecebidos && paridade_q;
        if (pop) slot_cheio_d = 1'b0;
        if (par_completo && !slot_cheio_d) begin
            slot_cheio_d = 1'b1;
            slot_cmd_d   = primeiroByte;
            slot_addr_d  = segundoByte;
        end

        case (estado_q)
            ESPERA: begin
                if (slot_cheio_q) begin
                    cmd_d    = slot_cmd_q;
                    addr_d   = slot_addr_q;
                    estado_d = VALIDA;
                end
`ifdef CONTINUOUS_MODE_EN
                else if (cont_temp_q) begin
                    cmd_d    = 8'h01;
                    addr_d   = cont_temp_addr_q;
                    estado_d = VALIDA;
                end else if (cont_hum_q) begin
                    cmd_d    = 8'h02;
                    addr_d   = cont_hum_addr_q;
                    estado_d = VALIDA;
                end
`endif
            end
            VALIDA: begin
                if (!cmd_ok) begin
                    cod_d    = 8'hCF;
                    dado_d   = 8'h00;
                    estado_d = ENVIA_CODIGO;
                end else if (!addr_ok) begin
                    cod_d    = 8'hEF;
                    dado_d   = 8'h00;
                    estado_d = ENVIA_CODIGO;
                end else if (usa_sensor) begin
                    endereco_d = addr_q[4:0];
                    tipo_d     = tipo_cmd;
                    estado_d   = REQUISITA;
`ifdef CONTINUOUS_MODE_EN
                    if (cmd_q == 8'h03) begin
                        cont_temp_d      = 1'b1;
                        cont_temp_addr_d = addr_q;
                    end
                    if (cmd_q == 8'h04) begin
                        cont_hum_d      = 1'b1;
                        cont_hum_addr_d = addr_q;
                    end
`endif
                end else begin
                    cod_d    = cod_imed;
                    dado_d   = 8'h00;
                    estado_d = ENVIA_CODIGO;
`ifdef CONTINUOUS_MODE_EN
                    if (cmd_q == 8'h05) cont_temp_d = 1'b0;
                    if (cmd_q == 8'h06) cont_hum_d = 1'b0;
`endif
                end
            end
            REQUISITA: begin
                cnt_d    = '0;
                estado_d = AGUARDA_SENSOR;
            end
            AGUARDA_SENSOR: begin
                // A completion in the timeout cycle wins.
                if (sensorPronto) begin
                    estado_d = ENVIA_CODIGO;
                    if (sensorErro) begin
                        cod_d  = 8'h1F;
                        dado_d = 8'h00;
                    end else begin
                        case (tipo_q)
                            2'd0: begin
                                cod_d  = 8'h07;
                                dado_d = 8'h00;
                            end
                            2'd1: begin
                                cod_d  = 8'h09;
                                dado_d = sensorDado;
                            end
                            default: begin
                                cod_d  = 8'h08;
                                dado_d = sensorDado;
                            end
                        endcase
                    end
                end else if (cnt_q == CNT_LIMITE) begin
                    cod_d    = 8'h1F;
                    dado_d   = 8'h00;
                    estado_d = ENVIA_CODIGO;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            ENVIA_CODIGO: begin
                if (!txOcupado) estado_d = AGUARDA_TX1;
            end
            AGUARDA_TX1: begin
                if (txConcluido) estado_d = ENVIA_DADO;
            end
            ENVIA_DADO: begin
                if (!txOcupado) estado_d = AGUARDA_TX2;
            end
            AGUARDA_TX2: begin
                if (txConcluido) estado_d = ESPERA;
            end
            default: estado_d = ESPERA;
        endcase

`ifdef CONTINUOUS_MODE_EN
        // Any faulted measurement drops its continuous flag.
        if (estado_q == AGUARDA_SENSOR && estado_d == ENVIA_CODIGO &&
            cod_d == 8'h1F) begin
            if (tipo_q == 2'd1) cont_temp_d = 1'b0;
            if (tipo_q == 2'd2) cont_hum_d = 1'b0;
        end
`endif

        // txByte is loaded as a send state is entered so it is valid
        // together with the txInicia strobe.
        if (estado_d == ENVIA_CODIGO) tx_byte_d = cod_d;
        if (estado_d == ENVIA_DADO) tx_byte_d = dado_q;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            estado_q     <= ESPERA;
            paridade_q   <= 1'b0;
            slot_cheio_q <= 1'b0;
            slot_cmd_q   <= '0;
            slot_addr_q  <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            endereco_q   <= '0;
            tipo_q       <= '0;
            cod_q        <= '0;
            dado_q       <= '0;
            tx_byte_q    <= '0;
            cnt_q        <= '0;
`ifdef CONTINUOUS_MODE_EN
            cont_temp_q      <= 1'b0;
            cont_hum_q       <= 1'b0;
            cont_temp_addr_q <= '0;
            cont_hum_addr_q  <= '0;
`endif
        end else begin
            estado_q     <= estado_d;
            paridade_q   <= paridade_d;
            slot_cheio_q <= slot_cheio_d;
            slot_cmd_q   <= slot_cmd_d;
            slot_addr_q  <= slot_addr_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            endereco_q   <= endereco_d;
            tipo_q       <= tipo_d;
            cod_q        <= cod_d;
            dado_q       <= dado_d;
            tx_byte_q    <= tx_byte_d;
            cnt_q        <= cnt_d;
`ifdef CONTINUOUS_MODE_EN
            cont_temp_q      <= cont_temp_d;
            cont_hum_q       <= cont_hum_d;
            cont_temp_addr_q <= cont_temp_addr_d;
            cont_hum_addr_q  <= cont_hum_addr_d;
`endif
        end
    end

    assign sensorRequisicao = (estado_q == REQUISITA);
    assign sensorEndereco   = endereco_q;
    assign sensorTipo       = tipo_q;
    assign txInicia         = ((estado_q == ENVIA_CODIGO) ||
                               (estado_q == ENVIA_DADO)) && !txOcupado;
    assign txByte           = tx_byte_q;
    assign ocupado          = (estado_q != ESPERA);

endmodule

// File: tb/tb_decodificador_comando.sv
// tb_decodificador_comando: directed + random bench with sensor/tx responders
// and a rule-level reference model of the request/response behaviour.
module tb_decodificador_comando;

    localparam int TMO = 1000;

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       bytesRecebidos = 1'b0;
    logic [7:0] primeiroByte = 8'h00;
    logic [7:0] segundoByte = 8'h00;
    logic       sensorRequisicao;
    logic [4:0] sensorEndereco;
    logic [1:0] sensorTipo;
    logic       sensorPronto;
    logic [7:0] sensorDado;
    logic       sensorErro;
    logic       txInicia;
    logic [7:0] txByte;
    logic       txOcupado;
    logic       txConcluido;
    logic       ocupado;

    decodificador_comando #(
        .CLOCKS_TIMEOUT(TMO),
        .NUM_SENSORES(32)
    ) dut (
        .clock(clock),
        .resetN(resetN),
        .bytesRecebidos(bytesRecebidos),
        .primeiroByte(primeiroByte),
        .segundoByte(segundoByte),
        .sensorRequisicao(sensorRequisicao),
        .sensorEndereco(sensorEndereco),
        .sensorTipo(sensorTipo),
        .sensorPronto(sensorPronto),
        .sensorDado(sensorDado),
        .sensorErro(sensorErro),
        .txInicia(txInicia),
        .txByte(txByte),
        .txOcupado(txOcupado),
        .txConcluido(txConcluido),
        .ocupado(ocupado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int pulse_cyc = 0;

    // sensor responder configuration
    int         s_delay = 10;
    bit         s_never = 1'b0;
    logic [7:0] s_dado = 8'h00;
    bit         s_erro = 1'b0;
    int         tx_busy = 3;

    int req_addr[$];
    int req_tipo[$];
    int req_cyc[$];
    int tx_q[$];
    int tx_cyc[$];

    initial begin : sensor_model
        sensorPronto = 1'b0;
        sensorDado = 8'h00;
        sensorErro = 1'b0;
        forever begin
            @(negedge clock);
            if (sensorRequisicao) begin
                req_addr.push_back(int'(sensorEndereco));
                req_tipo.push_back(int'(sensorTipo));
                req_cyc.push_back(cyc);
                if (!s_never) begin
                    repeat (s_delay) @(posedge clock);
                    #1;
                    sensorPronto = 1'b1;
                    sensorDado = s_dado;
                    sensorErro = s_erro;
                    @(posedge clock);
                    #1;
                    sensorPronto = 1'b0;
                    sensorErro = 1'b0;
                end
            end
        end
    end

    initial begin : tx_model
        txOcupado = 1'b0;
        txConcluido = 1'b0;
        forever begin
            @(negedge clock);
            if (txInicia) begin
                tx_q.push_back(int'(txByte));
                tx_cyc.push_back(cyc);
                @(posedge clock);
                #1 txOcupado = 1'b1;
                repeat (tx_busy) @(posedge clock);
                #1;
                txOcupado = 1'b0;
                txConcluido = 1'b1;
                @(posedge clock);
                #1 txConcluido = 1'b0;
            end
        end
    end

    function automatic int qv(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        req_addr.delete();
        req_tipo.delete();
        req_cyc.delete();
        tx_q.delete();
        tx_cyc.delete();
    endtask

    task automatic send_pair(input logic [7:0] c, input logic [7:0] a);
        @(posedge clock);
        #1;
        primeiroByte = c;
        segundoByte = a;
        bytesRecebidos = 1'b1;
        @(posedge clock);
        #1 bytesRecebidos = 1'b0;
        @(posedge clock);
        #1;
        bytesRecebidos = 1'b1;
        pulse_cyc = cyc;
        @(posedge clock);
        #1 bytesRecebidos = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k;
        k = 0;
        @(negedge clock);
        while ((tx_q.size() < n || ocupado) && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("wait_done", int'(k < budget), 1);
    endtask

    // Expected behaviour from the command table, independent of the FSM.
    function automatic void ref_model(
        input int c, input int a, input bit fault,
        input int d, output bit sens, output int tipo,
        output int code, output int data);
        bit known;
        sens = 1'b0;
        tipo = 0;
        data = 0;
`ifdef CONTINUOUS_MODE_EN
        known = (c <= 6);
`else
        known = (c <= 2);
`endif
        if (!known) code = 'hCF;
        else if (a >= 32) code = 'hEF;
        else if (c == 5) code = 'h0A;
        else if (c == 6) code = 'h0B;
        else begin
            sens = 1'b1;
            tipo = (c == 0) ? 0 : ((c == 1 || c == 3) ? 1 : 2);
            if (fault) code = 'h1F;
            else if (tipo == 0) code = 'h07;
            else if (tipo == 1) begin
                code = 'h09;
                data = d;
            end else begin
                code = 'h08;
                data = d;
            end
        end
    endfunction

    task automatic run_txn(input int c, input int a, input bit erro,
                           input int d, input int dly, input bit never);
        bit sens;
        int tipo, code, data;
        s_delay = dly;
        s_dado = 8'(d);
        s_erro = erro;
        s_never = never;
        clear_q();
        send_pair(8'(c), 8'(a));
        wait_tx(2, 3000);
        ref_model(c, a, erro || never, d, sens, tipo, code, data);
        check("req_count", req_addr.size(), int'(sens));
        if (sens) begin
            check("req_addr", qv(req_addr, 0), a);
            check("req_tipo", qv(req_tipo, 0), tipo);
            check("req_latency", qv(req_cyc, 0) - pulse_cyc, 3);
        end else begin
            check("tx_latency", qv(tx_cyc, 0) - pulse_cyc, 3);
        end
        check("tx_code", qv(tx_q, 0), code);
        check("tx_data", qv(tx_q, 1), data);
        check("tx_count", tx_q.size(), 2);
    endtask

    initial begin : main
        int k;
        int n;
        int c, a;
        resetN = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req", int'(sensorRequisicao), 0);
        check("rst_txini", int'(txInicia), 0);
        check("rst_txbyte", int'(txByte), 0);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_end", int'(sensorEndereco), 0);
        check("rst_tipo", int'(sensorTipo), 0);
        resetN = 1'b1;

        run_txn('h01, 'h05, 0, 25, 100, 0);
        run_txn('h02, 'h20, 0, 0, 5, 0);
        run_txn('h7A, 'h00, 0, 0, 5, 0);
        run_txn('h00, 31, 0, 'h55, 3, 0);
        run_txn('h01, 'hFF, 0, 0, 5, 0);
        run_txn('h02, 4, 1, 'h66, 7, 0);
`ifndef CONTINUOUS_MODE_EN
        run_txn('h03, 'h01, 0, 0, 5, 0);
`endif

        // sensor never answers: fault response after the timeout window
        run_txn('h00, 'h03, 0, 0, 1, 1);
        check("timeout_cycles", qv(tx_cyc, 0) - qv(req_cyc, 0), TMO + 1);
        s_never = 1'b0;

        for (int i = 0; i < 12; i++) begin
            k = int'($urandom_range(0, 4));
            c = (k <= 2) ? k : int'($urandom_range(7, 255));
            a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 31))
                                            : int'($urandom_range(32, 255));
            run_txn(c, a, ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 255)),
                    int'($urandom_range(1, 40)), 0);
        end

        // three pairs while the first waits on the sensor
        s_delay = 100;
        s_dado = 8'h33;
        s_erro = 1'b0;
        clear_q();
        send_pair(8'h01, 8'h05);
        k = 0;
        while (req_addr.size() == 0 && k < 50) begin
            @(negedge clock);
            k++;
        end
        send_pair(8'h02, 8'h07);
        send_pair(8'h00, 8'h09);
        wait_tx(4, 3000);
        repeat (200) @(posedge clock);
        @(negedge clock);
        check("b2b_tx_count", tx_q.size(), 4);
        check("b2b_req_count", req_addr.size(), 2);
        check("b2b_req2_addr", qv(req_addr, 1), 7);
        check("b2b_req2_tipo", qv(req_tipo, 1), 2);
        check("b2b_tx0", qv(tx_q, 0), 'h09);
        check("b2b_tx1", qv(tx_q, 1), 'h33);
        check("b2b_tx2", qv(tx_q, 2), 'h08);
        check("b2b_tx3", qv(tx_q, 3), 'h33);

        // reset while the code byte is in flight, with a half pair pending
        clear_q();
        tx_busy = 20;
        send_pair(8'h7A, 8'h00);
        k = 0;
        while (tx_q.size() == 0 && k < 50) begin
            @(negedge clock);
            k++;
        end
        @(posedge clock);
        #1 bytesRecebidos = 1'b1;
        @(posedge clock);
        #1 bytesRecebidos = 1'b0;
        @(posedge clock);
        #3 resetN = 1'b0;
        #1;
        check("mid_rst_req", int'(sensorRequisicao), 0);
        check("mid_rst_end", int'(sensorEndereco), 0);
        check("mid_rst_tipo", int'(sensorTipo), 0);
        check("mid_rst_txini", int'(txInicia), 0);
        check("mid_rst_txbyte", int'(txByte), 0);
        check("mid_rst_ocupado", int'(ocupado), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetN = 1'b1;
        repeat (40) @(posedge clock);
        tx_busy = 3;
        run_txn('h01, 'h0A, 0, 'h21, 6, 0);

`ifdef CONTINUOUS_MODE_EN
        clear_q();
        s_delay = 10;
        s_dado = 8'h44;
        s_erro = 1'b0;
        send_pair(8'h03, 8'h01);
        k = 0;
        while (tx_q.size() < 6 && k < 3000) begin
            @(negedge clock);
            k++;
        end
        for (int i = 0; i < 3; i++) begin
            check("cont_code", qv(tx_q, 2 * i), 'h09);
            check("cont_data", qv(tx_q, 2 * i + 1), 'h44);
            check("cont_addr", qv(req_addr, i), 1);
        end
        send_pair(8'h05, 8'h01);
        k = 0;
        while (k < 3000) begin
            @(negedge clock);
            k++;
            if (tx_q.size() >= 2 && qv(tx_q, tx_q.size() - 2) == 'h0A &&
                !ocupado) break;
        end
        n = tx_q.size();
        repeat (300) @(posedge clock);
        @(negedge clock);
        check("stop_code", qv(tx_q, n - 2), 'h0A);
        check("stop_data", qv(tx_q, n - 1), 'h00);
        check("stop_quiet", tx_q.size(), n);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
